// File: rtl/handshake_fifo_buffer_pkg.sv
// handshake_fifo_buffer_pkg: shared operation encoding and pointer-wrap helper for the elastic FIFO
package handshake_fifo_buffer_pkg;

    // Encoded as {push, pop} so the handshake bits cast directly into an operation
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_storage.sv
// handshake_fifo_storage: unreset slot array with one write port and one asynchronous read port
module handshake_fifo_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer: opaque elastic FIFO with registered ready/valid and 1-cycle minimum latency
module handshake_fifo_buffer
    import handshake_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    fifo_op_e         op;

    // Handshake flags decode only registered count, so no input-to-output path exists
    assign ins_ready  = count_q != CNT_W'(DEPTH);
    assign outs_valid = count_q != '0;
    assign push       = ins_valid && ins_ready;
    assign pop        = outs_valid && outs_ready;

    always_comb begin
        op       = fifo_op_e'({push, pop});
        wr_ptr_d = push ? PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = pop  ? PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        count_d  = (op == OP_PUSH) ? count_q + CNT_W'(1) :
                   (op == OP_POP)  ? count_q - CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    handshake_fifo_storage #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_storage (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(ins),
        .raddr(rd_ptr_q),
        .rdata(outs)
    );

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// tb_handshake_fifo_buffer: table-driven and scoreboard checks of the elastic FIFO at DEPTH=4 and DEPTH=3
module tb_handshake_fifo_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] in4 = '0, out4;
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0;
    logic [26:0] in3 = '0, out3;
    logic        iv3 = 1'b0, ir3, ov3, or3 = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    logic [26:0] q4[$];

    typedef struct {
        logic        v;
        logic [26:0] d;
        logic        r;
        logic        eir;
        logic        eov;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    handshake_fifo_buffer #(.DATA_WIDTH(27), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .ins(in4), .ins_valid(iv4), .ins_ready(ir4),
        .outs(out4), .outs_valid(ov4), .outs_ready(or4)
    );

    handshake_fifo_buffer #(.DATA_WIDTH(27), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .ins(in3), .ins_valid(iv3), .ins_ready(ir3),
        .outs(out3), .outs_valid(ov3), .outs_ready(or3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle on the DEPTH=4 instance; head payload comes from the scoreboard queue
    task automatic drive4(input logic v, input logic [26:0] d, input logic r,
                          input logic eir, input logic eov, input string tag);
        in4 = d; iv4 = v; or4 = r;
        chk({tag, ".ins_ready"}, 32'(ir4), 32'(eir));
        chk({tag, ".outs_valid"}, 32'(ov4), 32'(eov));
        if (eov) begin
            if (q4.size() == 0) chk({tag, ".scoreboard_empty"}, 32'(1), 32'(0));
            else chk({tag, ".outs"}, 32'(out4), 32'(q4[0]));
            if (r && q4.size() != 0) void'(q4.pop_front());
        end
        if (v && eir) q4.push_back(d);
        @(posedge clk); #1;
    endtask

    task automatic auto4(input logic v, input logic [26:0] d, input logic r, input string tag);
        logic eir, eov;
        eir = q4.size() != 4;
        eov = q4.size() != 0;
        drive4(v, d, r, eir, eov, tag);
    endtask

    initial begin
        int m3, nxt_in, nxt_out, cyc;
        for (int i = 0; i < 4; i++) tbl[i] = '{1'b1, 27'h741B945, 1'b0, 1'b1, i != 0};
        tbl[4] = '{1'b0, 27'h0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 27'h0, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 27'h0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 27'h0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 27'h0, 1'b0, 1'b1, 1'b0};

        #1;
        chk("reset.outs_valid", 32'(ov4), 32'(0));
        chk("reset.ins_ready", 32'(ir4), 32'(1));
        chk("reset.count", 32'(dut4.count_q), 32'(0));
        #3 rst = 1'b0;

        for (int i = 0; i < 9; i++)
            drive4(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].eir, tbl[i].eov, $sformatf("fill_drain[%0d]", i));

        for (int i = 0; i < 4; i++) auto4(1'b1, 27'(i + 1), 1'b0, "full_fill");
        auto4(1'b1, 27'h123, 1'b1, "full_both");
        chk("full_both.count", 32'(dut4.count_q), 32'(3));
        chk("full_both.ins_ready_next", 32'(ir4), 32'(1));
        for (int i = 0; i < 3; i++) auto4(1'b0, '0, 1'b1, "full_drain");
        auto4(1'b0, '0, 1'b0, "full_empty");

        for (int i = 0; i < 8; i++) begin
            auto4(1'b1, 27'(100 + i), 1'b1, "stream");
            chk("stream.count", 32'(dut4.count_q), 32'(1));
        end
        auto4(1'b0, '0, 1'b1, "stream_drain");
        auto4(1'b0, '0, 1'b0, "stream_empty");

        auto4(1'b1, 27'h5A5A5A5, 1'b0, "bp_push");
        for (int i = 0; i < 5; i++) auto4(1'b0, 27'h7FFFFFF, 1'b0, "bp_hold");
        auto4(1'b0, '0, 1'b1, "bp_drain");

        auto4(1'b1, 27'd11, 1'b0, "rst_fill");
        auto4(1'b1, 27'd22, 1'b0, "rst_fill");
        rst = 1'b1;
        #2;
        chk("midrst.outs_valid", 32'(ov4), 32'(0));
        chk("midrst.ins_ready", 32'(ir4), 32'(1));
        chk("midrst.count", 32'(dut4.count_q), 32'(0));
        rst = 1'b0;
        q4.delete();
        #1;
        auto4(1'b1, 27'h0A5, 1'b0, "after_rst_push");
        auto4(1'b0, '0, 1'b1, "after_rst_pop");
        auto4(1'b0, '0, 1'b0, "after_rst_empty");

        // DEPTH=3 wrap/order run: independent occupancy counter and expected-next-value model
        m3 = 0; nxt_in = 1; nxt_out = 1; cyc = 0;
        while (nxt_out <= 10 && cyc < 80) begin
            logic eir, eov, r, v;
            eir = m3 != 3;
            eov = m3 != 0;
            r = (cyc % 2) == 0;
            v = nxt_in <= 10;
            in3 = 27'(nxt_in); iv3 = v; or3 = r;
            chk("wrap.ins_ready", 32'(ir3), 32'(eir));
            chk("wrap.outs_valid", 32'(ov3), 32'(eov));
            if (eov && r) begin
                chk("wrap.outs", 32'(out3), 32'(nxt_out));
                nxt_out++;
                m3--;
            end
            if (v && eir) begin
                nxt_in++;
                m3++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("wrap.all_delivered", 32'(nxt_out), 32'(11));
        iv3 = 1'b0; or3 = 1'b0;
        #1;
        chk("wrap.final_empty", 32'(ov3), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_fifo_buffer.md
HANDSHAKE_FIFO_BUFFER -- requirements
Module: handshake_fifo_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the number of storage slots; legal range is DEPTH >= 2, any integer.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port ins, input, DATA_WIDTH bits: upstream payload.
REQ-006 SHALL have port ins_valid, input, 1 bit: upstream offers ins.
REQ-007 SHALL have port ins_ready, output, 1 bit: the buffer can accept ins.
REQ-008 SHALL have port outs, output, DATA_WIDTH bits: payload at the head of the buffer.
REQ-009 SHALL have port outs_valid, output, 1 bit: outs holds a buffered token.
REQ-010 SHALL have port outs_ready, input, 1 bit: downstream accepts outs.

Function
REQ-011 SHALL be an opaque elastic FIFO: a token is pushed on any rising edge where ins_valid && ins_ready, and popped on any rising edge where outs_valid && outs_ready.
REQ-012 SHALL drive ins_ready = (count != DEPTH) and outs_valid = (count != 0), both decoded from registered state only, with no combinational path from ins_valid or outs_ready.
REQ-013 SHALL have a minimum latency of 1 cycle: a token pushed at edge N is presented on outs with outs_valid=1 from edge N onward, never in the same cycle it arrives (no bypass).
REQ-014 SHALL deliver tokens in strict arrival order with payload bit-exact; outs SHALL equal the head slot whenever outs_valid=1, and its value is don't-care when outs_valid=0.
REQ-015 SHALL keep a write pointer and a read pointer, each ceil(log2(DEPTH)) bits, plus a count of ceil(log2(DEPTH+1)) bits.
REQ-016 SHALL wrap each pointer from DEPTH-1 to 0 on advance, including when DEPTH is not a power of two.
REQ-017 SHALL, on a simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-018 SHALL, when full, hold ins_ready=0 even if outs_ready=1; space freed by a pop becomes visible on the next cycle.
REQ-019 SHALL, when empty, hold outs_valid=0 regardless of ins_valid.
REQ-020 SHALL hold stored data and state unchanged when neither a push nor a pop occurs.
REQ-021 SHALL hold outs stable while outs_valid=1 and outs_ready=0.

Reset
REQ-022 SHALL, while rst=1, immediately force count=0, both pointers to 0, outs_valid=0 and ins_ready=1, with no clock edge required.
REQ-023 SHALL discard all buffered tokens on a reset asserted mid-operation, and SHALL NOT reset the storage array.
REQ-024 SHALL accept the first push on the first rising edge after rst deasserts.

Structure
REQ-025 SHALL derive the pointer and count widths as localparams inside the module; no shared package is required for this block.
REQ-026 SHALL isolate the storage in one sub-module, handshake_fifo_storage (parameters DATA_WIDTH and DEPTH; one write port, one asynchronous read port), with all control logic in the parent.

Verification
REQ-027 SHALL cover fill and drain: DATA_WIDTH=27, DEPTH=4, outs_ready=0, push 27'h741B945 four times -> ins_ready=0 after the 4th edge; then outs_ready=1 -> four tokens of 27'h741B945, then outs_valid=0.
REQ-028 SHALL cover ordering and wrap: push 1..10 through DEPTH=3 with outs_ready toggling 1,0,1,0 -> outs sequence exactly 1..10.
REQ-029 SHALL cover full with simultaneous events: full DEPTH=4 with ins_valid=1 and outs_ready=1 -> the pop occurs, no push in that cycle, count=3, and ins_ready=1 on the next cycle.
REQ-030 SHALL cover steady streaming: ins_valid=1 and outs_ready=1 continuously -> after 1 cycle of latency, one token per cycle with count constant at 1.
REQ-031 SHALL cover backpressure: outs_valid=1 and outs_ready=0 for 5 cycles -> outs unchanged across all 5 cycles.
REQ-032 SHALL cover reset mid-operation: 2 tokens held, rst pulsed between edges -> outs_valid=0 before the next edge, and the next pushed value 8'hA5 is the first token out.
